// File: rtl/pc_inst_dec.sv
`default_nettype none
// ============================================================================
//  Module   : pc_inst_dec
//  Purpose  : 14-bit byte-address program counter plus purely combinational
//             RV32I instruction decoder (raw fields, format/op-class flags,
//             unsigned immediates).
//  Revision : 1.0  - initial release
// ============================================================================
module pc_inst_dec (
    input  logic        clk,
    input  logic        rstB,
    input  logic        clkEn,
    input  logic [31:0] instruction_in,
    output logic [13:0] pc_out,
    output logic [6:0]  Op_code,
    output logic        r_type,
    output logic        i_type,
    output logic        s_type,
    output logic        b_type,
    output logic        u_type,
    output logic        j_type,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  reg_d,
    output logic [4:0]  reg_s1,
    output logic [4:0]  reg_s2,
    output logic [12:0] imm13_b,
    output logic [11:0] imm12_i_s,
    output logic [31:0] imm32_u,
    output logic [20:0] imm21_j,
    output logic        op_lui,
    output logic        op_auipc,
    output logic        op_jal,
    output logic        op_jalr,
    output logic        op_branch,
    output logic        op_memLd,
    output logic        op_intRegImm,
    output logic        op_memSt,
    output logic        op_consShf,
    output logic        op_intRegReg,
    output logic        op_efence,
    output logic        op_ecb
);

    localparam logic [6:0]  c_OPC_OP     = 7'b0110011;
    localparam logic [6:0]  c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0]  c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0]  c_OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0]  c_OPC_FENCE  = 7'b0001111;
    localparam logic [6:0]  c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0]  c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0]  c_OPC_JAL    = 7'b1101111;
    localparam logic [13:0] c_PC_STEP    = 14'd4;

    logic [13:0] r_pc;
    logic [6:0]  w_opc;

    assign w_opc  = instruction_in[6:0];
    assign pc_out = r_pc;

    // Program counter: reset wins over enable; natural 14-bit overflow wraps.
    always_ff @(posedge clk) begin
        if (rstB) begin
            r_pc <= 14'd0;
        end else if (clkEn) begin
            r_pc <= r_pc + c_PC_STEP;
        end
    end

    // Raw bit fields are passed straight through for every opcode.
    assign Op_code = w_opc;
    assign funct3  = instruction_in[14:12];
    assign funct7  = instruction_in[31:25];
    assign reg_d   = instruction_in[11:7];
    assign reg_s1  = instruction_in[19:15];
    assign reg_s2  = instruction_in[24:20];

    // Immediates are always computed; the flags tell the consumer which applies.
    assign imm12_i_s = s_type ? {instruction_in[31:25], instruction_in[11:7]}
                              : instruction_in[31:20];
    assign imm13_b   = {instruction_in[31], instruction_in[7],
                        instruction_in[30:25], instruction_in[11:8], 1'b0};
    assign imm32_u   = {instruction_in[31:12], 12'h000};
    assign imm21_j   = {instruction_in[31], instruction_in[19:12],
                        instruction_in[20], instruction_in[30:21], 1'b0};

    // Opcode-class decode: one-hot at most, all-zero for unrecognised opcodes.
    always_comb begin
        r_type       = 1'b0;
        i_type       = 1'b0;
        s_type       = 1'b0;
        b_type       = 1'b0;
        u_type       = 1'b0;
        j_type       = 1'b0;
        op_lui       = 1'b0;
        op_auipc     = 1'b0;
        op_jal       = 1'b0;
        op_jalr      = 1'b0;
        op_branch    = 1'b0;
        op_memLd     = 1'b0;
        op_intRegImm = 1'b0;
        op_memSt     = 1'b0;
        op_consShf   = 1'b0;
        op_intRegReg = 1'b0;
        op_efence    = 1'b0;
        op_ecb       = 1'b0;
        case (w_opc)
            c_OPC_OP: begin
                r_type       = 1'b1;
                op_intRegReg = 1'b1;
            end
            c_OPC_OPIMM: begin
                i_type = 1'b1;
                // SLLI/SRLI/SRAI (funct3 001/101) share the shift-by-constant class.
                if (instruction_in[13:12] == 2'b01) begin
                    op_consShf = 1'b1;
                end else begin
                    op_intRegImm = 1'b1;
                end
            end
            c_OPC_LOAD: begin
                i_type   = 1'b1;
                op_memLd = 1'b1;
            end
            c_OPC_JALR: begin
                i_type  = 1'b1;
                op_jalr = 1'b1;
            end
            c_OPC_SYSTEM: begin
                i_type = 1'b1;
                op_ecb = 1'b1;
            end
            c_OPC_FENCE: begin
                op_efence = 1'b1;
            end
            c_OPC_STORE: begin
                s_type   = 1'b1;
                op_memSt = 1'b1;
            end
            c_OPC_BRANCH: begin
                b_type    = 1'b1;
                op_branch = 1'b1;
            end
            c_OPC_LUI: begin
                u_type = 1'b1;
                op_lui = 1'b1;
            end
            c_OPC_AUIPC: begin
                u_type   = 1'b1;
                op_auipc = 1'b1;
            end
            c_OPC_JAL: begin
                j_type = 1'b1;
                op_jal = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_inst_dec.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_inst_dec
//  Purpose  : Self-checking bench for pc_inst_dec: directed and randomized
//             checks against an arithmetic/table reference model.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_pc_inst_dec;

    logic        clk = 1'b0;
    logic        rstB;
    logic        clkEn;
    logic [31:0] instruction_in;
    logic [13:0] pc_out;
    logic [6:0]  Op_code;
    logic        r_type, i_type, s_type, b_type, u_type, j_type;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  reg_d, reg_s1, reg_s2;
    logic [12:0] imm13_b;
    logic [11:0] imm12_i_s;
    logic [31:0] imm32_u;
    logic [20:0] imm21_j;
    logic        op_lui, op_auipc, op_jal, op_jalr, op_branch, op_memLd;
    logic        op_intRegImm, op_memSt, op_consShf, op_intRegReg, op_efence, op_ecb;

    int total = 0;
    int bad   = 0;
    int exp_pc = 0;   // integer model of the program counter

    always #5 clk = ~clk;

    pc_inst_dec dut (
        .clk(clk), .rstB(rstB), .clkEn(clkEn), .instruction_in(instruction_in),
        .pc_out(pc_out), .Op_code(Op_code),
        .r_type(r_type), .i_type(i_type), .s_type(s_type), .b_type(b_type),
        .u_type(u_type), .j_type(j_type),
        .funct3(funct3), .funct7(funct7),
        .reg_d(reg_d), .reg_s1(reg_s1), .reg_s2(reg_s2),
        .imm13_b(imm13_b), .imm12_i_s(imm12_i_s), .imm32_u(imm32_u), .imm21_j(imm21_j),
        .op_lui(op_lui), .op_auipc(op_auipc), .op_jal(op_jal), .op_jalr(op_jalr),
        .op_branch(op_branch), .op_memLd(op_memLd), .op_intRegImm(op_intRegImm),
        .op_memSt(op_memSt), .op_consShf(op_consShf), .op_intRegReg(op_intRegReg),
        .op_efence(op_efence), .op_ecb(op_ecb)
    );

    // All decoder outputs packed: 7+3+7+5+5+5+13+12+32+21+6+12 = 128 bits
    logic [127:0] dut_vec;
    assign dut_vec = {Op_code, funct3, funct7, reg_d, reg_s1, reg_s2,
                      imm13_b, imm12_i_s, imm32_u, imm21_j,
                      r_type, i_type, s_type, b_type, u_type, j_type,
                      op_lui, op_auipc, op_jal, op_jalr, op_branch, op_memLd,
                      op_intRegImm, op_memSt, op_consShf, op_intRegReg, op_efence, op_ecb};

    // Opcode table: opcode, type index (5=r..0=j, -1 none), op index (11=lui..0=ecb)
    int tbl_opc [11] = '{'h33, 'h13, 'h03, 'h67, 'h73, 'h0F, 'h23, 'h63, 'h37, 'h17, 'h6F};
    int tbl_typ [11] = '{5,    4,    4,    4,    4,    -1,   3,    2,    1,    1,    0};
    int tbl_op  [11] = '{2,    5,    6,    8,    0,    1,    4,    7,    11,   10,   9};

    function automatic logic [127:0] model(input logic [31:0] inst);
        int unsigned x;
        int unsigned opc, f3, imm_i, imm_s, imm_b, imm_j;
        logic [5:0]  typ;
        logic [11:0] ops;
        logic [11:0] imm12;
        x     = inst;
        opc   = x % 128;
        f3    = (x / 4096) % 8;
        typ   = '0;
        ops   = '0;
        for (int k = 0; k < 11; k++) begin
            if (opc == tbl_opc[k]) begin
                if (tbl_typ[k] >= 0) typ[tbl_typ[k]] = 1'b1;
                ops[tbl_op[k]] = 1'b1;
                if (opc == 'h13 && (f3 == 1 || f3 == 5)) ops = 12'b000000001000;
            end
        end
        imm_i = x >> 20;
        imm_s = ((x >> 25) << 5) + ((x >> 7) % 32);
        imm_b = ((x >> 31) << 12) + (((x >> 7) % 2) << 11)
              + (((x >> 25) % 64) << 5) + (((x >> 8) % 16) << 1);
        imm_j = ((x >> 31) << 20) + (((x >> 12) % 256) << 12)
              + (((x >> 20) % 2) << 11) + (((x >> 21) % 1024) << 1);
        imm12 = typ[3] ? imm_s[11:0] : imm_i[11:0];
        return {opc[6:0], f3[2:0], inst[31:25], inst[11:7], inst[19:15], inst[24:20],
                imm_b[12:0], imm12, x - (x % 4096), imm_j[20:0], typ, ops};
    endfunction

    task automatic test_reset();
        rstB = 1'b1; clkEn = 1'b1; instruction_in = 32'h40B50533;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            exp_pc = 0;
            total++;
            if (pc_out !== 14'(exp_pc)) begin
                bad++; $display("FAIL reset_pc got=%h want=%h", pc_out, 14'(exp_pc));
            end
            total++;
            if (dut_vec !== model(instruction_in)) begin
                bad++; $display("FAIL decode_in_reset got=%h want=%h", dut_vec, model(instruction_in));
            end
        end
        rstB = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (pc_out !== 14'(4 * i)) begin
                bad++; $display("FAIL count_%0d got=%h want=%h", i, pc_out, 14'(4 * i));
            end
        end
        exp_pc = 12;
        clkEn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (pc_out !== 14'h000C) begin
                bad++; $display("FAIL hold got=%h want=000c", pc_out);
            end
        end
    endtask

    task automatic test_random_count();
        for (int i = 0; i < 200; i++) begin
            clkEn = 1'($urandom);
            rstB  = ($urandom_range(0, 19) == 0);
            @(posedge clk); #1;
            if (rstB) exp_pc = 0;
            else if (clkEn) exp_pc = (exp_pc + 4) % 16384;
            total++;
            if (pc_out !== 14'(exp_pc)) begin
                bad++; $display("FAIL rand_pc step=%0d got=%h want=%h", i, pc_out, 14'(exp_pc));
            end
        end
        rstB = 1'b0;
    endtask

    task automatic test_midcount_reset();
        clkEn = 1'b1; rstB = 1'b0;
        repeat (5) @(posedge clk);
        rstB = 1'b1;
        @(posedge clk); #1;
        total++;
        if (pc_out !== 14'h0000) begin
            bad++; $display("FAIL midcount_reset got=%h want=0000", pc_out);
        end
        rstB = 1'b0;
        @(posedge clk); #1;
        total++;
        if (pc_out !== 14'h0004) begin
            bad++; $display("FAIL resume got=%h want=0004", pc_out);
        end
        exp_pc = 4;
    endtask

    task automatic test_wrap();
        clkEn = 1'b1; rstB = 1'b1;
        @(posedge clk); #1;
        rstB = 1'b0;
        repeat (4095) @(posedge clk);
        #1;
        total++;
        if (pc_out !== 14'h3FFC) begin
            bad++; $display("FAIL wrap_pre got=%h want=3ffc", pc_out);
        end
        @(posedge clk); #1;
        total++;
        if (pc_out !== 14'h0000) begin
            bad++; $display("FAIL wrap got=%h want=0000", pc_out);
        end
        clkEn = 1'b0;
        exp_pc = 0;
    endtask

    task automatic test_directed_decode();
        logic [12:0] bi;
        logic [11:0] si;
        logic [20:0] ji;
        logic [31:0] v [10];
        bi = 13'h1ABE; si = 12'h7E5; ji = 21'h1FFFFE;
        v[0] = 32'h40B50533;
        v[1] = {12'hABC, 5'd3, 3'b101, 5'd7, 7'b0010011};
        v[2] = {12'hABC, 5'd3, 3'b000, 5'd7, 7'b0010011};
        v[3] = {si[11:5], 5'd2, 5'd1, 3'b010, si[4:0], 7'b0100011};
        v[4] = {bi[12], bi[10:5], 5'd2, 5'd1, 3'b000, bi[4:1], bi[11], 7'b1100011};
        v[5] = {20'hFFFFF, 5'd9, 7'b0110111};
        v[6] = {20'h12345, 5'd9, 7'b0010111};
        v[7] = {ji[20], ji[10:1], ji[11], ji[19:12], 5'd1, 7'b1101111};
        v[8] = 32'hDEADBE80;
        v[9] = 32'h1234567F;
        for (int i = 0; i < 10; i++) begin
            instruction_in = v[i];
            #1;
            total++;
            if (dut_vec !== model(v[i])) begin
                bad++; $display("FAIL directed_%0d inst=%h got=%h want=%h", i, v[i], dut_vec, model(v[i]));
            end
        end
        // Literal expectations from the block's worked examples
        instruction_in = v[0]; #1;
        total++;
        if ({Op_code, funct7, reg_s2, reg_s1, funct3, reg_d, r_type, op_intRegReg}
            !== {7'h33, 7'h20, 5'd11, 5'd10, 3'd0, 5'd10, 1'b1, 1'b1}) begin
            bad++; $display("FAIL rtype_lit got=%h %h %0d %0d %0d %0d %b %b want=33 20 11 10 0 10 1 1",
                            Op_code, funct7, reg_s2, reg_s1, funct3, reg_d, r_type, op_intRegReg);
        end
        instruction_in = v[1]; #1;
        total++;
        if ({imm12_i_s, reg_s1, reg_d, i_type, op_consShf, op_intRegImm}
            !== {12'hABC, 5'd3, 5'd7, 1'b1, 1'b1, 1'b0}) begin
            bad++; $display("FAIL shift_lit got=%h %0d %0d %b %b %b want=abc 3 7 1 1 0",
                            imm12_i_s, reg_s1, reg_d, i_type, op_consShf, op_intRegImm);
        end
        instruction_in = v[3]; #1;
        total++;
        if ({imm12_i_s, s_type, op_memSt} !== {12'h7E5, 1'b1, 1'b1}) begin
            bad++; $display("FAIL store_lit got=%h %b %b want=7e5 1 1", imm12_i_s, s_type, op_memSt);
        end
        instruction_in = v[4]; #1;
        total++;
        if ({imm13_b, b_type, op_branch} !== {13'h1ABE, 1'b1, 1'b1}) begin
            bad++; $display("FAIL branch_lit got=%h %b %b want=1abe 1 1", imm13_b, b_type, op_branch);
        end
        instruction_in = v[5]; #1;
        total++;
        if ({imm32_u, u_type, op_lui} !== {32'hFFFFF000, 1'b1, 1'b1}) begin
            bad++; $display("FAIL lui_lit got=%h %b %b want=fffff000 1 1", imm32_u, u_type, op_lui);
        end
        instruction_in = v[7]; #1;
        total++;
        if ({imm21_j, j_type, op_jal} !== {21'h1FFFFE, 1'b1, 1'b1}) begin
            bad++; $display("FAIL jal_lit got=%h %b %b want=1ffffe 1 1", imm21_j, j_type, op_jal);
        end
        instruction_in = v[9]; #1;
        total++;
        if ({r_type, i_type, s_type, b_type, u_type, j_type, op_lui, op_auipc, op_jal, op_jalr,
             op_branch, op_memLd, op_intRegImm, op_memSt, op_consShf, op_intRegReg, op_efence, op_ecb}
            !== 18'd0 || Op_code !== 7'h7F || reg_s1 !== 5'd8) begin
            bad++; $display("FAIL unknown_lit got_flags_nonzero_or_fields opc=%h rs1=%0d want opc=7f rs1=8 flags=0",
                            Op_code, reg_s1);
        end
    endtask

    task automatic test_random_decode();
        logic [31:0] inst;
        for (int i = 0; i < 400; i++) begin
            inst = $urandom;
            // Bias toward recognised opcodes so every class is exercised
            if (i % 4 != 0) inst[6:0] = 7'(tbl_opc[$urandom_range(0, 10)]);
            instruction_in = inst;
            clkEn = 1'($urandom);
            rstB  = 1'($urandom);
            #1;
            total++;
            if (dut_vec !== model(inst)) begin
                bad++; $display("FAIL rand_decode inst=%h got=%h want=%h", inst, dut_vec, model(inst));
            end
            #2;
        end
        rstB = 1'b0; clkEn = 1'b0;
    endtask

    initial begin
        rstB = 1'b1; clkEn = 1'b0; instruction_in = '0;
        #1;
        test_reset();
        test_random_count();
        test_midcount_reset();
        test_wrap();
        test_directed_decode();
        test_random_decode();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_inst_dec.md
PC_INST_DEC -- requirements
Module: pc_inst_dec

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port rstB  input  1  synchronous, active-high reset.
REQ-003 SHALL have port clkEn  input  1  PC advance enable.
REQ-004 SHALL have port instruction_in  input  32  instruction word to decode.
REQ-005 SHALL have port pc_out  output  14  registered byte-address program counter.
REQ-006 SHALL have port Op_code  output  7  instruction_in[6:0].
REQ-007 SHALL have ports r_type, i_type, s_type, b_type, u_type, j_type  output  1 each  format flags.
REQ-008 SHALL have port funct3  output  3  instruction_in[14:12].
REQ-009 SHALL have port funct7  output  7  instruction_in[31:25].
REQ-010 SHALL have ports reg_d, reg_s1, reg_s2  output  5 each  instruction_in[11:7], [19:15], [24:20].
REQ-011 SHALL have port imm13_b  output  13  B-type immediate.
REQ-012 SHALL have port imm12_i_s  output  12  I/S-type immediate.
REQ-013 SHALL have port imm32_u  output  32  U-type immediate.
REQ-014 SHALL have port imm21_j  output  21  J-type immediate.
REQ-015 SHALL have ports op_lui, op_auipc, op_jal, op_jalr, op_branch, op_memLd, op_intRegImm, op_memSt, op_consShf, op_intRegReg, op_efence, op_ecb  output  1 each  opcode-class flags.

Function
REQ-016 SHALL increment pc_out by 4 on each rising edge with rstB=0 and clkEn=1; hold when clkEn=0.
REQ-017 SHALL wrap pc_out modulo 2^14 (0x3FFC + 4 -> 0x0000); pc_out[1:0] always 0.
REQ-018 SHALL implement the decoder as purely combinational logic, zero-cycle latency, independent of clk/rstB/clkEn.
REQ-019 SHALL output Op_code, funct3, funct7, reg_d, reg_s1, reg_s2 as raw bit fields for every opcode, including unrecognised ones.
REQ-020 SHALL decode opcodes: 0110011 r_type+op_intRegReg; 0010011 i_type, with op_consShf if funct3 is 001 or 101 else op_intRegImm; 0000011 i_type+op_memLd; 1100111 i_type+op_jalr; 1110011 i_type+op_ecb; 0001111 op_efence only; 0100011 s_type+op_memSt; 1100011 b_type+op_branch; 0110111 u_type+op_lui; 0010111 u_type+op_auipc; 1101111 j_type+op_jal.
REQ-021 SHALL keep all type and op flags 0 for any other opcode; at most one type flag and one op flag high at once.
REQ-022 SHALL form imm12_i_s = {inst[31:25],inst[11:7]} when s_type, else inst[31:20]; unsigned, no extension.
REQ-023 SHALL form imm13_b = {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}.
REQ-024 SHALL form imm32_u = {inst[31:12],12'h000}.
REQ-025 SHALL form imm21_j = {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}.
REQ-026 SHALL compute immediates for every opcode regardless of flags.

Reset
REQ-027 SHALL load pc_out = 0x0000 on a rising edge with rstB=1, overriding clkEn.
REQ-028 SHALL give reset priority when asserted mid-count; counting resumes from 0 on the first enabled edge after release.
REQ-029 SHALL leave decoder outputs unaffected by reset.

Verification
REQ-030 Reset 2 cycles, release with clkEn=1, 3 edges -> pc_out 0x0000, 0x0004, 0x0008, 0x000C; clkEn=0 -> holds.
REQ-031 R-type 0x40B50533 -> Op_code 0x33, funct7 0x20, reg_s2 11, reg_s1 10, funct3 0, reg_d 10, r_type=1, op_intRegReg=1.
REQ-032 I-type {12'hABC,5'd3,3'b101,5'd7,7'b0010011} -> imm12_i_s 0xABC, reg_s1 3, reg_d 7, i_type=1, op_consShf=1; funct3 000 -> op_intRegImm=1.
REQ-033 S-type imm 0x7E5 funct3 010 -> imm12_i_s 0x7E5, s_type=1, op_memSt=1; B-type imm 0x1ABE -> imm13_b 0x1ABE, b_type=1, op_branch=1.
REQ-034 LUI inst[31:12]=0xFFFFF -> imm32_u 0xFFFFF000, u_type=1, op_lui=1; AUIPC -> op_auipc=1; JAL imm 0x1FFFFE -> imm21_j 0x1FFFFE, j_type=1, op_jal=1.
REQ-035 Opcode 0x00 and 0x7F -> all type/op flags 0, raw fields still correct; pc wrap 0x3FFC -> 0x0000.
